rating_display_ctrl: RTL and testbench
======================================

RATING_DISPLAY_CTRL -- requirements
Module: rating_display_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SCORE_W, 20: score width.
- MAX_SCORE, 1000000: score giving "SS".
- T_S, 900000: minimum score for S.
- T_A, 850000: minimum score for A.
- T_B, 800000: minimum score for b.
- T_C, 700000: minimum score for C.
- BLINK_HALF, 12500000: cycles per blink phase.
- BLINK_TOGGLES, 6: blink phases in the reveal.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: sole clock.
- resetn, in, 1: synchronous active-low reset.
- score, in, SCORE_W: running score.
- score_valid, in, 1: score update strobe.
- song_start, in, 1: one-cycle pulse, song begins.
- song_end, in, 1: one-cycle pulse, song ends.
- rating_hi, out, 4: HEX5 seven-segment code.
- rating_lo, out, 4: HEX4 seven-segment code.
- grade, out, 3: current grade.
- best_grade, out, 3: best final grade since reset.
- final_valid, out, 1: final rating is being shown steady.
- new_best, out, 1: one-cycle pulse, best grade improved.
REQ-003 One clock domain; reset is synchronous and active-low, named clk and resetn. No other clock or reset.

Function
REQ-004 Grade encoding: 0 F, 1 C, 2 b, 3 A, 4 S, 5 SS.
REQ-005 Classification: score>=MAX_SCORE gives SS; else >=T_S gives S; >=T_A gives A; >=T_B gives b; >=T_C gives C; else F. Comparisons are unsigned, at full SCORE_W width.
REQ-006 Display codes (hi/lo): SS 5/5; S 14/5; A 14/10; b 14/11; C 14/12; F 14/13. Blank is 14/14.
REQ-007 FSM states: IDLE, LIVE, REVEAL, HOLD.
REQ-008 IDLE behaviour:
- Display blank, grade=0.
- song_start enters LIVE next cycle with grade cleared to F.
REQ-009 LIVE behaviour:
- On score_valid, grade and display update exactly 1 cycle later from the sampled score.
- Without score_valid, grade holds.
REQ-010 LIVE + song_end: enter REVEAL.
- If score_valid is asserted in the same cycle, the final grade uses that score.
- Otherwise the final grade is the held grade.
REQ-011 REVEAL behaviour:
- A phase counter runs BLINK_HALF cycles per phase.
- The display starts blank, then alternates grade/blank.
- After BLINK_TOGGLES phases, enter HOLD.
- score_valid is ignored in REVEAL.
REQ-012 HOLD behaviour:
- Steady final grade display, final_valid=1.
- song_start enters LIVE.
- score_valid and song_end are ignored.
REQ-013 On the REVEAL-to-HOLD transition:
- If final grade > best_grade, update best_grade and pulse new_best for exactly 1 cycle.
- An equal or lower grade does not update best_grade and does not pulse new_best.
REQ-014 song_start in REVEAL aborts the reveal: enter LIVE, grade F, best_grade unchanged.
REQ-015 song_start and song_end in the same cycle: song_start wins in every state.
REQ-016 song_end in IDLE or HOLD is ignored.
REQ-017 The blink counter is wide enough for BLINK_HALF-1 and clears on every state entry.
REQ-018 final_valid is 1 only in HOLD.
REQ-019 All outputs are registered.

Reset
REQ-020 When resetn=0 at a clk edge, the following take effect next cycle:
- State IDLE.
- rating_hi=rating_lo=14, grade=0, best_grade=0.
- final_valid=0, new_best=0, counters 0.
REQ-021 Reset mid-REVEAL or mid-HOLD discards the final grade and the best grade.

Structure
REQ-022 Shared package rhythm_pkg holds:
- Grade encoding constants.
- Seven-segment code constants (5, 10-14).
- FSM state type.
REQ-023 One combinational sub-module, grade_classify (score plus thresholds in, grade out), instantiated once. Code mapping is done in the parent.

Verification
REQ-024 Bench uses BLINK_HALF=4, BLINK_TOGGLES=6 and covers:
- Reset, then song_start, then score=850000 with score_valid: one cycle later grade=3, hi/lo=14/10.
- Scores 699999, 700000, 899999, 999999, 1000000, 1048575: grades 0, 1, 3, 4, 5, 5; the last two show 5/5.
- score=900000 with score_valid and song_end in the same cycle:
  - Blank 4 cycles, then 14/5 for 4 cycles, alternating for 24 cycles total.
  - Then HOLD with final_valid=1, best_grade=4, new_best pulses once.
- Second song with final 800000: best_grade stays 4, new_best stays 0.
- song_start at cycle 10 of REVEAL: LIVE next cycle, grade 0, best_grade unchanged.
- song_start and song_end together in LIVE: stays LIVE, grade 0.
- resetn low in HOLD: all outputs at reset values next cycle.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared grade encoding, seven-segment display codes and FSM state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rhythm_pkg;

    // Grade encoding, ordered so that a larger value is a better grade.
    localparam logic [2:0] GRADE_F  = 3'd0;
    localparam logic [2:0] GRADE_C  = 3'd1;
    localparam logic [2:0] GRADE_B  = 3'd2;
    localparam logic [2:0] GRADE_A  = 3'd3;
    localparam logic [2:0] GRADE_S  = 3'd4;
    localparam logic [2:0] GRADE_SS = 3'd5;

    // Seven-segment character codes understood by the HEX decoders.
    localparam logic [3:0] SEG_5     = 4'd5;
    localparam logic [3:0] SEG_A     = 4'd10;
    localparam logic [3:0] SEG_B     = 4'd11;
    localparam logic [3:0] SEG_C     = 4'd12;
    localparam logic [3:0] SEG_F     = 4'd13;
    localparam logic [3:0] SEG_BLANK = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LIVE,
        ST_REVEAL,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/grade_classify.sv
// Maps a score onto a grade using descending unsigned thresholds.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
// Ports: score and the five thresholds (all SCORE_W wide) in, 3-bit grade out.
module grade_classify
    import rhythm_pkg::*;
#(
    parameter int unsigned SCORE_W = 20
) (
    input  logic [SCORE_W-1:0] score,
    input  logic [SCORE_W-1:0] max_score,
    input  logic [SCORE_W-1:0] t_s,
    input  logic [SCORE_W-1:0] t_a,
    input  logic [SCORE_W-1:0] t_b,
    input  logic [SCORE_W-1:0] t_c,
    output logic [2:0]         grade
);

    always_comb begin
        grade = GRADE_F;
        if (score >= max_score)  grade = GRADE_SS;
        else if (score >= t_s)   grade = GRADE_S;
        else if (score >= t_a)   grade = GRADE_A;
        else if (score >= t_b)   grade = GRADE_B;
        else if (score >= t_c)   grade = GRADE_C;
    end

endmodule

// File: rtl/rating_display_ctrl.sv
// Rating display controller: live grade, blinking end-of-song reveal, best grade tracking.
// Latency: every output registered; a sampled score shows on grade/display one cycle later.
// Backpressure: none; score_valid/song_start/song_end are strobes acted on the cycle they arrive.
// Ports: clk, resetn (sync, active-low); score/score_valid/song_start/song_end in;
//        rating_hi/rating_lo (HEX5/HEX4 codes), grade, best_grade, final_valid, new_best out.
module rating_display_ctrl
    import rhythm_pkg::*;
#(
    parameter int unsigned SCORE_W       = 20,
    parameter int unsigned MAX_SCORE     = 1000000,
    parameter int unsigned T_S           = 900000,
    parameter int unsigned T_A           = 850000,
    parameter int unsigned T_B           = 800000,
    parameter int unsigned T_C           = 700000,
    parameter int unsigned BLINK_HALF    = 12500000,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    input  logic               song_start,
    input  logic               song_end,
    output logic [3:0]         rating_hi,
    output logic [3:0]         rating_lo,
    output logic [2:0]         grade,
    output logic [2:0]         best_grade,
    output logic               final_valid,
    output logic               new_best
);

    localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned PH_W  = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BLINK_HALF - 1);
    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(BLINK_TOGGLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  blink_cnt;
    logic [PH_W-1:0]   phase;
    logic [2:0]        live_grade;
    logic [2:0]        final_grade;

    grade_classify #(
        .SCORE_W (SCORE_W)
    ) u_classify (
        .score     (score),
        .max_score (SCORE_W'(MAX_SCORE)),
        .t_s       (SCORE_W'(T_S)),
        .t_a       (SCORE_W'(T_A)),
        .t_b       (SCORE_W'(T_B)),
        .t_c       (SCORE_W'(T_C)),
        .grade     (live_grade)
    );

    // A score arriving together with song_end is the last word on the result.
    assign final_grade = score_valid ? live_grade : grade;

    // {hi, lo} display pair for a grade; only SS uses the left digit.
    function automatic logic [7:0] grade_code(input logic [2:0] g);
        case (g)
            GRADE_SS: grade_code = {SEG_5,     SEG_5};
            GRADE_S:  grade_code = {SEG_BLANK, SEG_5};
            GRADE_A:  grade_code = {SEG_BLANK, SEG_A};
            GRADE_B:  grade_code = {SEG_BLANK, SEG_B};
            GRADE_C:  grade_code = {SEG_BLANK, SEG_C};
            default:  grade_code = {SEG_BLANK, SEG_F};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            rating_hi   <= SEG_BLANK;
            rating_lo   <= SEG_BLANK;
            grade       <= GRADE_F;
            best_grade  <= GRADE_F;
            final_valid <= 1'b0;
            new_best    <= 1'b0;
            blink_cnt   <= '0;
            phase       <= '0;
        end else begin
            new_best <= 1'b0;
            // song_start restarts a song from any state and beats song_end.
            if (song_start) begin
                state                  <= ST_LIVE;
                grade                  <= GRADE_F;
                {rating_hi, rating_lo} <= {SEG_BLANK, SEG_F};
                final_valid            <= 1'b0;
                blink_cnt              <= '0;
                phase                  <= '0;
            end else begin
                case (state)
                    ST_LIVE: begin
                        if (song_end) begin
                            state                  <= ST_REVEAL;
                            grade                  <= final_grade;
                            {rating_hi, rating_lo} <= {SEG_BLANK, SEG_BLANK};
                            blink_cnt              <= '0;
                            phase                  <= '0;
                        end else if (score_valid) begin
                            grade                  <= live_grade;
                            {rating_hi, rating_lo} <= grade_code(live_grade);
                        end
                    end
                    ST_REVEAL: begin
                        if (blink_cnt == LAST_CNT) begin
                            blink_cnt <= '0;
                            if (phase == LAST_PHASE) begin
                                state                  <= ST_HOLD;
                                {rating_hi, rating_lo} <= grade_code(grade);
                                final_valid            <= 1'b1;
                                phase                  <= '0;
                                if (grade > best_grade) begin
                                    best_grade <= grade;
                                    new_best   <= 1'b1;
                                end
                            end else begin
                                phase <= phase + 1'b1;
                                // Even phases are blank, odd phases show the grade.
                                if (phase[0])
                                    {rating_hi, rating_lo} <= {SEG_BLANK, SEG_BLANK};
                                else
                                    {rating_hi, rating_lo} <= grade_code(grade);
                            end
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and HOLD only react to song_start, handled above.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rating_display_ctrl.sv
module tb_rating_display_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [19:0] score;
    logic        score_valid;
    logic        song_start;
    logic        song_end;
    logic [3:0]  rating_hi;
    logic [3:0]  rating_lo;
    logic [2:0]  grade;
    logic [2:0]  best_grade;
    logic        final_valid;
    logic        new_best;

    always #5 clk = ~clk;

    rating_display_ctrl #(
        .BLINK_HALF    (4),
        .BLINK_TOGGLES (6)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .score       (score),
        .score_valid (score_valid),
        .song_start  (song_start),
        .song_end    (song_end),
        .rating_hi   (rating_hi),
        .rating_lo   (rating_lo),
        .grade       (grade),
        .best_grade  (best_grade),
        .final_valid (final_valid),
        .new_best    (new_best)
    );

    typedef struct {
        int    cyc;
        string name;
        int    hi, lo, g, best, fv, nb;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue the outputs expected after the edge that samples them.
    task automatic step(input int st, input int en, input int sv, input int sc,
                        input int hi, input int lo, input int g, input int best,
                        input int fv, input int nb, input string name);
        exp_t e;
        song_start  = (st != 0);
        song_end    = (en != 0);
        score_valid = (sv != 0);
        score       = 20'(sc);
        e.cyc  = cyc + 1;
        e.name = name;
        e.hi = hi; e.lo = lo; e.g = g; e.best = best; e.fv = fv; e.nb = nb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares outputs against the queued expectation for this cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.cyc < cyc) begin
                fails++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (int'(rating_hi) != e.hi || int'(rating_lo) != e.lo || int'(grade) != e.g ||
                         int'(best_grade) != e.best || int'(final_valid) != e.fv || int'(new_best) != e.nb) begin
                fails++;
                $display("FAIL %s @%0d: got hi=%0d lo=%0d grade=%0d best=%0d fv=%0d nb=%0d, want hi=%0d lo=%0d grade=%0d best=%0d fv=%0d nb=%0d",
                         e.name, cyc, rating_hi, rating_lo, grade, best_grade, final_valid, new_best,
                         e.hi, e.lo, e.g, e.best, e.fv, e.nb);
            end
        end
    end

    initial begin
        resetn      = 1'b0;
        score       = '0;
        score_valid = 1'b0;
        song_start  = 1'b0;
        song_end    = 1'b0;
        @(posedge clk);
        #1;

        // Reset and idle
        step(0,0,0,0,        14,14,0,0,0,0, "reset");
        resetn = 1'b1;
        step(0,0,0,0,        14,14,0,0,0,0, "idle_blank");
        step(0,1,1,900000,   14,14,0,0,0,0, "end_in_idle");

        // Song 1: live grading
        step(1,0,0,0,        14,13,0,0,0,0, "start1");
        step(0,0,1,850000,   14,10,3,0,0,0, "s850000");
        step(0,0,0,123,      14,10,3,0,0,0, "live_hold");
        step(0,0,1,699999,   14,13,0,0,0,0, "s699999");
        step(0,0,1,700000,   14,12,1,0,0,0, "s700000");
        step(0,0,1,800000,   14,11,2,0,0,0, "s800000");
        step(0,0,1,899999,   14,10,3,0,0,0, "s899999");
        step(0,0,1,999999,   14, 5,4,0,0,0, "s999999");
        step(0,0,1,1000000,   5, 5,5,0,0,0, "s1000000");
        step(0,0,1,1048575,   5, 5,5,0,0,0, "s1048575");

        // Reveal with final score 900000 (S)
        step(0,1,1,900000,   14,14,4,0,0,0, "reveal1_start");
        for (int k = 1; k < 24; k++) begin
            if ((k / 4) % 2 == 1) step(0,0,1,0, 14, 5,4,0,0,0, "reveal1_on");
            else                  step(0,0,1,0, 14,14,4,0,0,0, "reveal1_off");
        end
        step(0,0,0,0,        14,5,4,4,1,1, "hold1_new_best");
        step(0,1,1,0,        14,5,4,4,1,0, "hold1_ignore");

        // Song 2: final 800000 (b) does not beat S
        step(1,0,0,0,        14,13,0,4,0,0, "start2");
        step(0,1,1,800000,   14,14,2,4,0,0, "reveal2_start");
        for (int k = 1; k < 24; k++) begin
            if ((k / 4) % 2 == 1) step(0,0,0,0, 14,11,2,4,0,0, "reveal2_on");
            else                  step(0,0,0,0, 14,14,2,4,0,0, "reveal2_off");
        end
        step(0,0,0,0,        14,11,2,4,1,0, "hold2_no_best");
        step(0,0,0,0,        14,11,2,4,1,0, "hold2_steady");

        // Song 3: SS reveal aborted at reveal cycle 10
        step(1,0,0,0,        14,13,0,4,0,0, "start3");
        step(0,0,1,1000000,   5, 5,5,4,0,0, "s3_ss");
        step(0,1,0,0,        14,14,5,4,0,0, "reveal3_start");
        for (int k = 1; k <= 10; k++) begin
            if ((k / 4) % 2 == 1) step(0,0,0,0,  5, 5,5,4,0,0, "reveal3_on");
            else                  step(0,0,0,0, 14,14,5,4,0,0, "reveal3_off");
        end
        step(1,0,0,0,        14,13,0,4,0,0, "abort_reveal");

        // song_start and song_end together in LIVE
        step(0,0,1,899999,   14,10,3,4,0,0, "s4_live");
        step(1,1,0,0,        14,13,0,4,0,0, "start_end_same");
        step(0,0,0,0,        14,13,0,4,0,0, "still_live");

        // Finish with SS to reach HOLD with a new best, then reset in HOLD
        step(0,1,1,1000000,  14,14,5,4,0,0, "reveal4_start");
        for (int k = 1; k < 24; k++) begin
            if ((k / 4) % 2 == 1) step(0,0,0,0,  5, 5,5,4,0,0, "reveal4_on");
            else                  step(0,0,0,0, 14,14,5,4,0,0, "reveal4_off");
        end
        step(0,0,0,0,         5, 5,5,5,1,1, "hold4_new_best");
        resetn = 1'b0;
        step(0,0,0,0,        14,14,0,0,0,0, "reset_in_hold");
        resetn = 1'b1;
        step(0,1,1,900000,   14,14,0,0,0,0, "idle_after_reset");

        repeat (3) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
